decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/decode_stage.sv | 195 +++++++++++++++++++
 tb/tb_decode_stage.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_stage.sv
// ---------------------------------------------------------------------------
// decode_stage
//
// Instruction decode stage with a two-entry skid FIFO on its output.
// Each accepted instruction is sliced into opcode / reg_dest / reg_source_1 /
// reg_source_2 / immediate (MSB to LSB) when it is pushed. The immediate is
// extended to DATA_WIDTH, and a per-opcode legality flag is attached. The
// decoded entry is stored, and the head entry drives the outputs.
//
// Ports
//   clk            in   single clock, rising edge
//   rst            in   synchronous active-high reset (priority over flush)
//   flush          in   synchronous flush: empties the FIFO, ignores push/pop
//   in_valid       in   instruction present
//   in_ready       out  stage can accept (registered state only)
//   instruction    in   raw instruction, INSTRUCTION_WIDTH bits
//   out_valid      out  decoded head entry present
//   out_ready      in   consumer accepts the head entry
//   opcode         out  head opcode field
//   reg_dest       out  head destination register address
//   reg_source_1   out  head first source register address
//   reg_source_2   out  head second source register address
//   immediate      out  head immediate, extended to DATA_WIDTH
//   illegal        out  head opcode is not in VALID_OP_MASK
//   decoded_count  out  number of entries popped, wraps at 16 bits
// ---------------------------------------------------------------------------
module decode_stage #(
    parameter int OPCODE_WIDTH      = 5,
    parameter int REG_ADDR_WIDTH    = 4,
    parameter int IMM_WIDTH         = 16,
    parameter int DATA_WIDTH        = 32,
    parameter int INSTRUCTION_WIDTH = OPCODE_WIDTH + 3 * REG_ADDR_WIDTH + IMM_WIDTH,
    parameter logic [(2**OPCODE_WIDTH)-1:0] SIGNED_IMM_MASK = 32'h0000_4040,
    parameter logic [(2**OPCODE_WIDTH)-1:0] VALID_OP_MASK   = 32'h0000_407F
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [INSTRUCTION_WIDTH-1:0] instruction,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [OPCODE_WIDTH-1:0]      opcode,
    output logic [REG_ADDR_WIDTH-1:0]    reg_dest,
    output logic [REG_ADDR_WIDTH-1:0]    reg_source_1,
    output logic [REG_ADDR_WIDTH-1:0]    reg_source_2,
    output logic [DATA_WIDTH-1:0]        immediate,
    output logic                         illegal,
    output logic [15:0]                  decoded_count
);

    // Field positions, counted from the LSB of the instruction word.
    localparam int RS2_LSB = IMM_WIDTH;
    localparam int RS1_LSB = RS2_LSB + REG_ADDR_WIDTH;
    localparam int RD_LSB  = RS1_LSB + REG_ADDR_WIDTH;
    localparam int OP_LSB  = RD_LSB + REG_ADDR_WIDTH;

    // -----------------------------------------------------------------------
    // Push-time decode
    // -----------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0]   dec_opcode;
    logic [REG_ADDR_WIDTH-1:0] dec_reg_dest;
    logic [REG_ADDR_WIDTH-1:0] dec_reg_source_1;
    logic [REG_ADDR_WIDTH-1:0] dec_reg_source_2;
    logic [IMM_WIDTH-1:0]      dec_imm_raw;
    logic [DATA_WIDTH-1:0]     dec_imm_ext;
    logic                      dec_signed;
    logic                      dec_illegal;
    logic                      sign_fill;

    assign dec_opcode       = instruction[OP_LSB  +: OPCODE_WIDTH];
    assign dec_reg_dest     = instruction[RD_LSB  +: REG_ADDR_WIDTH];
    assign dec_reg_source_1 = instruction[RS1_LSB +: REG_ADDR_WIDTH];
    assign dec_reg_source_2 = instruction[RS2_LSB +: REG_ADDR_WIDTH];
    assign dec_imm_raw      = instruction[0       +: IMM_WIDTH];

    assign dec_signed  = SIGNED_IMM_MASK[dec_opcode];
    assign dec_illegal = ~VALID_OP_MASK[dec_opcode];

    // Upper bits replicate the raw sign bit only for sign-extending opcodes.
    assign sign_fill = dec_signed & dec_imm_raw[IMM_WIDTH-1];

    // Bit-by-bit build of the extended immediate; also covers the case
    // DATA_WIDTH == IMM_WIDTH, where no fill bits exist.
    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_imm_ext
            if (gi < IMM_WIDTH) begin : g_raw
                assign dec_imm_ext[gi] = dec_imm_raw[gi];
            end else begin : g_fill
                assign dec_imm_ext[gi] = sign_fill;
            end
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Two-entry FIFO of decoded entries
    // -----------------------------------------------------------------------
    logic [OPCODE_WIDTH-1:0]   opcode_mem       [0:1];
    logic [REG_ADDR_WIDTH-1:0] reg_dest_mem     [0:1];
    logic [REG_ADDR_WIDTH-1:0] reg_source_1_mem [0:1];
    logic [REG_ADDR_WIDTH-1:0] reg_source_2_mem [0:1];
    logic [DATA_WIDTH-1:0]     immediate_mem    [0:1];
    logic                      illegal_mem      [0:1];

    logic [1:0]  count_reg, count_next;
    logic        head_reg, head_next;
    logic        tail_reg, tail_next;
    logic [15:0] decoded_count_reg, decoded_count_next;

    logic push_fire;
    logic pop_fire;
    logic write_en;

    // Handshake flags come from registered occupancy only, so in_ready never
    // depends on out_ready and there is no combinational path through the stage.
    assign in_ready  = (count_reg != 2'd2);
    assign out_valid = (count_reg != 2'd0);

    assign push_fire = in_valid & in_ready;
    assign pop_fire  = out_valid & out_ready;
    assign write_en  = push_fire & ~flush;

    always_comb begin
        count_next         = count_reg;
        head_next          = head_reg;
        tail_next          = tail_reg;
        decoded_count_next = decoded_count_reg;
        if (flush) begin
            // Drop everything buffered; handshakes this cycle have no effect.
            count_next = 2'd0;
            head_next  = 1'b0;
            tail_next  = 1'b0;
        end else begin
            if (push_fire) begin
                tail_next = ~tail_reg;
            end
            if (pop_fire) begin
                head_next          = ~head_reg;
                decoded_count_next = decoded_count_reg + 16'd1;
            end
            // Push and pop together leave occupancy unchanged; the freshly
            // written slot becomes the head because head advances onto it.
            case ({push_fire, pop_fire})
                2'b10:   count_next = count_reg + 2'd1;
                2'b01:   count_next = count_reg - 2'd1;
                default: count_next = count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg         <= 2'd0;
            head_reg          <= 1'b0;
            tail_reg          <= 1'b0;
            decoded_count_reg <= 16'd0;
            for (int i = 0; i < 2; i++) begin
                opcode_mem[i]       <= '0;
                reg_dest_mem[i]     <= '0;
                reg_source_1_mem[i] <= '0;
                reg_source_2_mem[i] <= '0;
                immediate_mem[i]    <= '0;
                illegal_mem[i]      <= 1'b0;
            end
        end else begin
            count_reg         <= count_next;
            head_reg          <= head_next;
            tail_reg          <= tail_next;
            decoded_count_reg <= decoded_count_next;
            if (write_en) begin
                opcode_mem[tail_reg]       <= dec_opcode;
                reg_dest_mem[tail_reg]     <= dec_reg_dest;
                reg_source_1_mem[tail_reg] <= dec_reg_source_1;
                reg_source_2_mem[tail_reg] <= dec_reg_source_2;
                immediate_mem[tail_reg]    <= dec_imm_ext;
                illegal_mem[tail_reg]      <= dec_illegal;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Head entry outputs; forced to zero whenever the FIFO is empty so stale
    // slot contents left behind by a flush never leak out.
    // -----------------------------------------------------------------------
    assign opcode        = out_valid ? opcode_mem[head_reg]       : '0;
    assign reg_dest      = out_valid ? reg_dest_mem[head_reg]     : '0;
    assign reg_source_1  = out_valid ? reg_source_1_mem[head_reg] : '0;
    assign reg_source_2  = out_valid ? reg_source_2_mem[head_reg] : '0;
    assign immediate     = out_valid ? immediate_mem[head_reg]    : '0;
    assign illegal       = out_valid ? illegal_mem[head_reg]      : 1'b0;
    assign decoded_count = decoded_count_reg;

endmodule

// File: tb/tb_decode_stage.sv
// ---------------------------------------------------------------------------
// tb_decode_stage
//
// Directed bench for decode_stage at default parameters. A queue-based model
// of the decoded-entry buffer is updated on every rising edge from the same
// inputs the DUT sees; a compare process checks every DUT output against it
// on each falling edge. Hand-computed literal expectations pin the model.
// ---------------------------------------------------------------------------
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [32:0] instruction = '0;
    logic        in_ready;
    logic        out_valid;
    logic [4:0]  opcode;
    logic [3:0]  reg_dest;
    logic [3:0]  reg_source_1;
    logic [3:0]  reg_source_2;
    logic [31:0] immediate;
    logic        illegal;
    logic [15:0] decoded_count;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .instruction   (instruction),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .opcode        (opcode),
        .reg_dest      (reg_dest),
        .reg_source_1  (reg_source_1),
        .reg_source_2  (reg_source_2),
        .immediate     (immediate),
        .illegal       (illegal),
        .decoded_count (decoded_count)
    );

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;
    bit verbose = 1'b1;

    // Per-opcode tables as variables so they can be indexed freely.
    logic [31:0] signed_tab = 32'h0000_4040;
    logic [31:0] valid_tab  = 32'h0000_407F;

    typedef struct packed {
        logic [4:0]  op;
        logic [3:0]  rd;
        logic [3:0]  rs1;
        logic [3:0]  rs2;
        logic [31:0] imm;
        logic        ill;
    } ent_t;

    ent_t        mq[$];
    logic [15:0] mcount;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Decode by plain arithmetic on the instruction value.
    function automatic ent_t model_decode(input logic [32:0] ins);
        ent_t        e;
        logic [32:0] v;
        logic [15:0] raw;
        v     = ins;
        e.op  = 5'((v >> 28) & 33'h1F);
        e.rd  = 4'((v >> 24) & 33'hF);
        e.rs1 = 4'((v >> 20) & 33'hF);
        e.rs2 = 4'((v >> 16) & 33'hF);
        raw   = 16'(v & 33'hFFFF);
        e.imm = {16'h0000, raw};
        if (signed_tab[e.op] && raw >= 16'h8000) e.imm = e.imm + 32'hFFFF_0000;
        e.ill = ~valid_tab[e.op];
        return e;
    endfunction

    // Reference model: queue of at most two decoded entries.
    initial begin : model
        bit   do_push;
        bit   do_pop;
        ent_t e;
        mcount = 16'd0;
        forever begin
            @(posedge clk);
            do_push = in_valid && (mq.size() < 2);
            do_pop  = (mq.size() > 0) && out_ready;
            if (rst) begin
                mq.delete();
                mcount = 16'd0;
            end else if (flush) begin
                mq.delete();
            end else begin
                if (do_pop) begin
                    e = mq.pop_front();
                    mcount = mcount + 16'd1;
                    if (verbose)
                        $display("pop #%0d op=%02h rd=%0h rs1=%0h rs2=%0h imm=%08h illegal=%0d",
                                 mcount, e.op, e.rd, e.rs1, e.rs2, e.imm, e.ill);
                end
                if (do_push) mq.push_back(model_decode(instruction));
            end
            started = 1'b1;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    initial begin : compare
        ent_t e;
        forever begin
            @(negedge clk);
            if (started) begin
                e = '0;
                if (mq.size() != 0) e = mq[0];
                check("out_valid",     32'(out_valid),     32'(mq.size() != 0));
                check("in_ready",      32'(in_ready),      32'(mq.size() != 2));
                check("opcode",        32'(opcode),        32'(e.op));
                check("reg_dest",      32'(reg_dest),      32'(e.rd));
                check("reg_source_1",  32'(reg_source_1),  32'(e.rs1));
                check("reg_source_2",  32'(reg_source_2),  32'(e.rs2));
                check("immediate",     immediate,          e.imm);
                check("illegal",       32'(illegal),       32'(e.ill));
                check("decoded_count", 32'(decoded_count), 32'(mcount));
            end
        end
    end

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin : stimulus
        int c;
        int n;
        cyc();
        cyc();
        rst = 1'b0;
        // Reset state
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst in_ready",  32'(in_ready),  32'd1);
        check("rst count",     32'(decoded_count), 32'd0);
        check("rst immediate", immediate, 32'd0);

        // Zero-extended immediate, then pop
        instruction = 33'h011000010; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        check("t1 valid",  32'(out_valid), 32'd1);
        check("t1 opcode", 32'(opcode), 32'h01);
        check("t1 rd",     32'(reg_dest), 32'h1);
        check("t1 rs1",    32'(reg_source_1), 32'h0);
        check("t1 rs2",    32'(reg_source_2), 32'h0);
        check("t1 imm",    immediate, 32'h0000_0010);
        check("t1 ill",    32'(illegal), 32'd0);
        cyc();
        check("t1 count",  32'(decoded_count), 32'd1);
        check("t1 empty",  32'(out_valid), 32'd0);

        // Sign-extended immediate
        instruction = 33'h0E130FFFD; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        in_valid = 1'b0;
        check("t2 opcode", 32'(opcode), 32'h0E);
        check("t2 rd",     32'(reg_dest), 32'h1);
        check("t2 rs1",    32'(reg_source_1), 32'h3);
        check("t2 imm",    immediate, 32'hFFFF_FFFD);
        check("t2 ill",    32'(illegal), 32'd0);
        out_ready = 1'b1;
        cyc();
        check("t2 count",  32'(decoded_count), 32'd2);

        // Register fields, then an illegal opcode pushed while popping
        instruction = 33'h052210000; in_valid = 1'b1;
        cyc();
        check("t3 opcode", 32'(opcode), 32'h05);
        check("t3 rd",     32'(reg_dest), 32'h2);
        check("t3 rs1",    32'(reg_source_1), 32'h2);
        check("t3 rs2",    32'(reg_source_2), 32'h1);
        check("t3 imm",    immediate, 32'h0);
        instruction = 33'h1F0000123;
        cyc();
        in_valid = 1'b0;
        check("t3 ill op",  32'(opcode), 32'h1F);
        check("t3 ill",     32'(illegal), 32'd1);
        check("t3 ill imm", immediate, 32'h0000_0123);
        check("t3 count",   32'(decoded_count), 32'd3);
        cyc();
        check("t3 count2",  32'(decoded_count), 32'd4);

        // Backpressure: fill, hold third, drain in order
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 33'h021200007;
        cyc();
        instruction = 33'h034560008;
        cyc();
        check("bp full",     32'(in_ready), 32'd0);
        instruction = 33'h047890009;
        cyc();
        check("bp held",     32'(in_ready), 32'd0);
        check("bp head1",    immediate, 32'd7);
        cyc();
        check("bp stable",   immediate, 32'd7);
        check("bp stable op", 32'(opcode), 32'h02);
        out_ready = 1'b1;
        cyc();
        check("bp head2",    immediate, 32'd8);
        check("bp head2 rs2", 32'(reg_source_2), 32'h6);
        check("bp cnt5",     32'(decoded_count), 32'd5);
        cyc();
        in_valid = 1'b0;
        check("bp head3",    immediate, 32'd9);
        check("bp cnt6",     32'(decoded_count), 32'd6);
        cyc();
        check("bp drained",  32'(out_valid), 32'd0);
        check("bp cnt7",     32'(decoded_count), 32'd7);

        // Flush with full FIFO and an instruction offered
        out_ready = 1'b0; in_valid = 1'b1;
        instruction = 33'h050000001;
        cyc();
        instruction = 33'h050000002;
        cyc();
        check("fl full", 32'(in_ready), 32'd0);
        flush = 1'b1; instruction = 33'h0600000AA;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl valid", 32'(out_valid), 32'd0);
        check("fl ready", 32'(in_ready), 32'd1);
        check("fl cnt",   32'(decoded_count), 32'd7);
        cyc();
        check("fl dropped", 32'(out_valid), 32'd0);

        // Flush while a push and a pop are both offered: neither happens
        in_valid = 1'b1; out_ready = 1'b1; instruction = 33'h061000055;
        cyc();
        flush = 1'b1; instruction = 33'h062000066;
        cyc();
        flush = 1'b0; in_valid = 1'b0;
        check("fl2 valid", 32'(out_valid), 32'd0);
        check("fl2 cnt",   32'(decoded_count), 32'd7);

        // Streaming to wrap decoded_count
        verbose = 1'b0;
        c = int'(mcount);
        n = 65536 - c;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < n; i++) begin
            instruction = {1'($urandom), 32'($urandom)};
            cyc();
        end
        check("wrap ffff", 32'(decoded_count), 32'h0000_FFFF);
        in_valid = 1'b0;
        cyc();
        check("wrap zero", 32'(decoded_count), 32'd0);
        check("wrap empty", 32'(out_valid), 32'd0);
        verbose = 1'b1;

        // Reset in the middle of a transfer
        instruction = 33'h071000001; in_valid = 1'b1; out_ready = 1'b1;
        cyc();
        in_valid = 1'b0;
        cyc();
        check("mr cnt1", 32'(decoded_count), 32'd1);
        instruction = 33'h072000002; in_valid = 1'b1; out_ready = 1'b0;
        cyc();
        check("mr valid", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1; instruction = 33'h073000003;
        cyc();
        rst = 1'b0; in_valid = 1'b0;
        check("mr out_valid", 32'(out_valid), 32'd0);
        check("mr cnt0",      32'(decoded_count), 32'd0);
        check("mr in_ready",  32'(in_ready), 32'd1);
        check("mr opcode",    32'(opcode), 32'd0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
